// File: rtl/bitwise_checker_pkg.sv
// Shared definitions for the bitwise stimulus/response checker.
//   state_t   : checker FSM states
//   MSK_*     : bit positions inside the 5-bit per-output mismatch mask
//   nv(w)     : number of exhaustive a/b vectors for operand width w
package bitwise_checker_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int MSK_INV_A = 0;
  localparam int MSK_INV_B = 1;
  localparam int MSK_AND   = 2;
  localparam int MSK_OR    = 3;
  localparam int MSK_XOR   = 4;

  function automatic int nv(input int w);
    return 1 << (2 * w);
  endfunction

endpackage

// File: rtl/bitwise_checker_if.sv
// Stimulus/response bus between the checker and a `bitwise` instance.
//   a, b                           : operands driven by the checker
//   a_inv, b_inv, a_and_b,
//   a_or_b, a_xor_b                : responses returned by the DUT
// master = checker side, slave = DUT side.
interface bitwise_checker_if #(
  parameter int W = 1
);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] a_inv;
  logic [W-1:0] b_inv;
  logic [W-1:0] a_and_b;
  logic [W-1:0] a_or_b;
  logic [W-1:0] a_xor_b;

  modport master (
    output a, b,
    input  a_inv, b_inv, a_and_b, a_or_b, a_xor_b
  );

  modport slave (
    input  a, b,
    output a_inv, b_inv, a_and_b, a_or_b, a_xor_b
  );
endinterface

// File: rtl/bitwise_golden.sv
// Combinational reference model of the `bitwise` block.
//   a, b          : operands
//   exp_a_inv ... : expected ~a, ~b, a&b, a|b, a^b
module bitwise_golden #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] exp_a_inv,
  output logic [W-1:0] exp_b_inv,
  output logic [W-1:0] exp_and,
  output logic [W-1:0] exp_or,
  output logic [W-1:0] exp_xor
);
  assign exp_a_inv = ~a;
  assign exp_b_inv = ~b;
  assign exp_and   = a & b;
  assign exp_or    = a | b;
  assign exp_xor   = a ^ b;
endmodule

// File: rtl/bitwise_checker.sv
// Self-checking stimulus engine for the `bitwise` block.
// Walks all 2^(2W) a/b combinations, waits SETTLE_CYCLES per vector, then
// compares the DUT outputs with bitwise_golden and accumulates results.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle pulse, starts a run from IDLE or DONE
//   dut        : master side of the stimulus/response bus
//   busy/done  : run in progress / run finished (held until next start)
//   pass       : valid with done, high when no vector mismatched
//   err_count  : saturating count of mismatching vectors
//   fail_a/b   : operands of the first failing vector
//   fail_mask  : per-output mismatch of the first failing vector
module bitwise_checker
  import bitwise_checker_pkg::*;
#(
  parameter int W             = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  bitwise_checker_if.master dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [4:0]       fail_mask
);
  localparam int NV = nv(W);
  localparam int IW = 2 * W;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_CHECK  = CHECK;
  localparam logic [1:0] ST_DONE   = DONE;

  localparam logic [IW-1:0] IDX_LAST   = IW'(NV - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q, b_q;

  logic [W-1:0] g_a_inv, g_b_inv, g_and, g_or, g_xor;
  logic [4:0]       mask;
  logic             mism;
  logic [ERR_W-1:0] err_nxt;

  assign dut.a = a_q;
  assign dut.b = b_q;

  bitwise_golden #(.W(W)) u_golden (
    .a         (a_q),
    .b         (b_q),
    .exp_a_inv (g_a_inv),
    .exp_b_inv (g_b_inv),
    .exp_and   (g_and),
    .exp_or    (g_or),
    .exp_xor   (g_xor)
  );

  always_comb begin
    mask            = '0;
    mask[MSK_INV_A] = |(dut.a_inv   ^ g_a_inv);
    mask[MSK_INV_B] = |(dut.b_inv   ^ g_b_inv);
    mask[MSK_AND]   = |(dut.a_and_b ^ g_and);
    mask[MSK_OR]    = |(dut.a_or_b  ^ g_or);
    mask[MSK_XOR]   = |(dut.a_xor_b ^ g_xor);
  end

  assign mism    = |mask;
  // Counter sticks at all-ones instead of wrapping back to a "clean" value.
  assign err_nxt = (mism && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
  assign idx_nxt = idx + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_mask <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cnt       <= CNT_RELOAD;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_CHECK;
          else           cnt   <= cnt - CW'(1);
        end
        ST_CHECK: begin
          err_count <= err_nxt;
          // Only the first failing vector is recorded; later ones just count.
          if (mism && err_count == '0) begin
            fail_a    <= a_q;
            fail_b    <= b_q;
            fail_mask <= mask;
          end
          if (idx == IDX_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
            state <= ST_DONE;
          end else begin
            idx        <= idx_nxt;
            {a_q, b_q} <= idx_nxt;
            cnt        <= CNT_RELOAD;
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_checker.sv
module tb_bitwise_checker;

  typedef struct {
    int err;
    int pass;
    int fa;
    int fb;
    int mask;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;
  int   mode;          // 0 correct, 1 and stuck 0, 2 xor stuck 1
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance 1: W=1, SETTLE=2, ERR_W=8
  bitwise_checker_if #(.W(1)) bus1 ();
  logic       busy1, done1, pass1;
  logic [7:0] err1;
  logic       fa1, fb1;
  logic [4:0] fm1;

  bitwise_checker #(.W(1), .SETTLE_CYCLES(2), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1), .fail_mask(fm1)
  );

  always_comb begin
    bus1.a_inv   = ~bus1.a;
    bus1.b_inv   = ~bus1.b;
    bus1.a_and_b = bus1.a & bus1.b;
    bus1.a_or_b  = bus1.a | bus1.b;
    bus1.a_xor_b = bus1.a ^ bus1.b;
    if (mode == 1) bus1.a_and_b = 1'b0;
    if (mode == 2) bus1.a_xor_b = 1'b1;
  end

  // ---------------- instance 2: W=2, SETTLE=2, ERR_W=2, all outputs inverted
  bitwise_checker_if #(.W(2)) bus2 ();
  logic       busy2, done2, pass2;
  logic [1:0] err2, fa2, fb2;
  logic [4:0] fm2;

  bitwise_checker #(.W(2), .SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut(bus2.master),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(fa2), .fail_b(fb2), .fail_mask(fm2)
  );

  assign bus2.a_inv   = bus2.a;
  assign bus2.b_inv   = bus2.b;
  assign bus2.a_and_b = ~(bus2.a & bus2.b);
  assign bus2.a_or_b  = ~(bus2.a | bus2.b);
  assign bus2.a_xor_b = ~(bus2.a ^ bus2.b);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor 1: vector order, latency and final results
  logic       busy1_q = 1'b0, done1_q = 1'b0;
  logic [1:0] ab1_q = '0;
  int         t0_1 = 0, vexp1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy1 && !busy1_q) begin
        t0_1  = cyc;
        vexp1 = 0;
        chk("vec_first", int'({bus1.a, bus1.b}), 0);
      end else if (busy1 && {bus1.a, bus1.b} != ab1_q) begin
        vexp1++;
        chk("vec_order", int'({bus1.a, bus1.b}), vexp1);
      end
      if (done1 && !done1_q) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("err_count1", int'(err1), e.err);
          chk("pass1",      int'(pass1), e.pass);
          chk("fail_a1",    int'(fa1), e.fa);
          chk("fail_b1",    int'(fb1), e.fb);
          chk("fail_mask1", int'(fm1), e.mask);
          chk("latency1",   cyc - t0_1, e.cyc);
          chk("vec_count1", vexp1, 3);
        end
      end
    end
    busy1_q = busy1;
    done1_q = done1;
    ab1_q   = {bus1.a, bus1.b};
  end

  // ---------------- monitor 2
  logic busy2_q = 1'b0, done2_q = 1'b0;
  int   t0_2 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy2 && !busy2_q) t0_2 = cyc;
      if (done2 && !done2_q) begin
        if (q2.size() == 0) chk("unexpected_done2", 1, 0);
        else begin
          e = q2.pop_front();
          chk("err_count2", int'(err2), e.err);
          chk("pass2",      int'(pass2), e.pass);
          chk("fail_a2",    int'(fa2), e.fa);
          chk("fail_b2",    int'(fb2), e.fb);
          chk("fail_mask2", int'(fm2), e.mask);
          chk("latency2",   cyc - t0_2, e.cyc);
        end
      end
    end
    busy2_q = busy2;
    done2_q = done2;
  end

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic wait_done1();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    if (!seen) chk("timeout_done1", 0, 1);
  endtask

  task automatic wait_done2();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done2) seen = 1'b1;
    end
    if (!seen) chk("timeout_done2", 0, 1);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_err",  int'(err1), 0);
    chk("rst_ab",   int'({bus1.a, bus1.b}), 0);
    chk("rst_fail", int'({fa1, fb1, fm1}), 0);
    rst = 1'b0;

    // run 1: correct DUT
    q1.push_back('{err: 0, pass: 1, fa: 0, fb: 0, mask: 0, cyc: 12});
    pulse_start1();
    wait_done1();

    // run 2: a_and_b stuck at 0, only (1,1) fails
    mode = 1;
    q1.push_back('{err: 1, pass: 0, fa: 1, fb: 1, mask: 5'b00100, cyc: 12});
    pulse_start1();
    wait_done1();

    // run 3: a_xor_b stuck at 1, (0,0) and (1,1) fail; first one retained.
    // Starting from DONE with results present must clear them on the same edge.
    mode = 2;
    q1.push_back('{err: 2, pass: 0, fa: 0, fb: 0, mask: 5'b10000, cyc: 12});
    pulse_start1();
    chk("restart_busy", int'(busy1), 1);
    chk("restart_done", int'(done1), 0);
    chk("restart_err",  int'(err1), 0);
    chk("restart_mask", int'(fm1), 0);
    chk("restart_fab",  int'({fa1, fb1}), 0);
    wait_done1();

    // instance 2: every vector fails, counter saturates at 3
    q2.push_back('{err: 3, pass: 0, fa: 0, fb: 0, mask: 5'b11111, cyc: 48});
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    wait_done2();

    // run 4: start held high for the whole run must not restart it
    mode = 0;
    q1.push_back('{err: 0, pass: 1, fa: 0, fb: 0, mask: 0, cyc: 12});
    @(negedge clk) start1 = 1'b1;
    repeat (12) @(negedge clk);
    start1 = 1'b0;
    wait_done1();

    // run 5: reset during SETTLE of vector 2 (a=1,b=0); no done expected
    mode = 1;
    pulse_start1();
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (bus1.a == 1'b1 && bus1.b == 1'b0) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reach_vec2", int'(hit), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy1), 0);
    chk("abort_ab",   int'({bus1.a, bus1.b}), 0);
    chk("abort_err",  int'(err1), 0);
    chk("abort_done", int'(done1), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", int'(busy1), 0);
    chk("idle_done", int'(done1), 0);

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bitwise_checker.md
Name: bitwise_checker

Overview:
Synthesizable, self-checking stimulus/response engine for the `bitwise` block; it is the hardware counterpart of the software bench. It drives exhaustive `a`/`b` vectors into a `bitwise` instance and waits a programmable settle time. It then samples the five DUT outputs, compares them against a golden model, and reports pass/fail, mismatch count and first failure. It runs inside FPGA emulation builds, where no simulator `$display` is available.

Parameters:
- W, 1, operand width of a/b; legal 1..4; vector count NV = 2^(2W)
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling DUT outputs; legal >= 1
- ERR_W, 8, width of the saturating mismatch counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- a  out  W  stimulus operand A to DUT
- b  out  W  stimulus operand B to DUT
- a_inv  in  W  DUT response
- b_inv  in  W  DUT response
- a_and_b  in  W  DUT response
- a_or_b  in  W  DUT response
- a_xor_b  in  W  DUT response
- busy  out  1  high while a run is in progress
- done  out  1  high from end of run until next start or reset
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  ERR_W  mismatching vectors, saturating at 2^ERR_W-1
- fail_a  out  W  a value of the first failing vector
- fail_b  out  W  b value of the first failing vector
- fail_mask  out  5  per-output mismatch of first failure; bit0 a_inv, bit1 b_inv, bit2 and, bit3 or, bit4 xor

Behaviour:
- Reset: state IDLE, a=b=0, busy=done=pass=0, err_count=0, fail_a=fail_b=0, fail_mask=0. All registered outputs clear immediately on rst assertion.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start: idx<=0, a<=0, b<=0, err_count<=0, fail_*<=0, pass<=0, done<=0, busy<=1, settle counter<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: decrement counter; at 0, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle), per output:
  - compare against golden: ~a, ~b, a&b, a|b, a^b; any bit differing sets that output's mask bit.
  - mismatch: err_count increments, saturating.
  - first mismatch only (err_count==0 before this check): capture fail_a, fail_b, fail_mask.
- CHECK, idx==NV-1: go to DONE; busy<=0, done<=1, pass<=(final err_count==0).
- CHECK, otherwise: idx<=idx+1; a/b update to new idx; counter reloads; go to SETTLE.
- Vector order: idx is 2W bits; a=idx[2W-1:W] (outer), b=idx[W-1:0] (inner).
- a/b are registered and change only on the cycle leaving IDLE/DONE or leaving CHECK.
- Latency: start sampled at edge 0 gives done=1 after edge NV*(SETTLE_CYCLES+1).
- start while busy: ignored, no restart, no effect on counters.
- start in DONE: restarts; all results clear on the same edge busy rises.
- Reset mid-run: immediate abort to IDLE; results cleared; no done pulse.
- idx wrap never occurs: the run ends at NV-1.

Decomposition:
- Package `bitwise_checker_pkg`:
  - state_t enum {IDLE, SETTLE, CHECK, DONE}
  - mask bit index constants MSK_INV_A=0, MSK_INV_B=1, MSK_AND=2, MSK_OR=3, MSK_XOR=4
  - function nv(W)
- Sub-module `bitwise_golden`: purely combinational expected-value generator (a, b -> five expected W-bit outputs). Kept separate so it can be reused by other checkers.

Test Plan:
- W=1, SETTLE_CYCLES=2, correct `bitwise` DUT, start pulse -> busy for 12 cycles, then done=1, pass=1, err_count=0, fail_mask=0; a/b sequence (0,0),(0,1),(1,0),(1,1).
- DUT a_and_b stuck at 0 -> err_count=1, pass=0, fail_a=1, fail_b=1, fail_mask=5'b00100.
- DUT a_xor_b stuck at 1 -> err_count=2, fail_a=0, fail_b=0, fail_mask=5'b10000 (first failure retained over the later (1,1) failure).
- W=2, ERR_W=2, DUT with all outputs inverted -> 16 vectors all fail; err_count saturates at 3; fail_mask=5'b11111, fail_a=0, fail_b=0; done after 48 cycles.
- Start pulses repeated every cycle during a run -> the run completes in exactly NV*(SETTLE_CYCLES+1) cycles, unaffected; start in DONE -> results cleared and new run begins.
- rst asserted during SETTLE of vector 2 -> same cycle: busy=0, a=b=0, err_count=0; after deassertion the block stays IDLE until start.
